// File: rtl/byte_word_packer_pkg.sv
// rtl/byte_word_packer_pkg.sv - shared word/keep types and state enum for the byte-to-word packer
package byte_word_packer_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [3:0] keep_t;

  typedef struct packed {
    logic [7:0] byte3;
    logic [7:0] byte2;
    logic [7:0] byte1;
    logic [7:0] byte0;
  } word_bytes_t;

  typedef union packed {
    logic [31:0] data;
    word_bytes_t bytes;
  } genericUnion_t;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } packer_state_t;

  // last_idx is the logical index of the final real byte (0..3)
  function automatic keep_t keep_mask(input logic [1:0] last_idx, input bit lsb_first);
    keep_t k;
    if (lsb_first) k = keep_t'(4'hF >> (2'd3 - last_idx));
    else           k = keep_t'(4'hF << (2'd3 - last_idx));
    return k;
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// rtl/byte_word_packer_if.sv - byte-in / word-out handshake bundle for the packer
interface byte_word_packer_if;
  import byte_word_packer_pkg::*;

  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  genericUnion_t m_data;
  keep_t         m_keep;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs an 8-bit byte stream into 32-bit words with keep mask and last flag
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter bit         LSB_FIRST = 1'b1,
  parameter logic [7:0] PAD_VALUE = 8'h00
) (
  input logic                clk,
  input logic                rst,
  byte_word_packer_if.slave  bus
);

  logic [2:0][7:0] r_lane;
  logic [1:0]      r_count;
  packer_state_t   r_state;
  genericUnion_t   r_m_data;
  keep_t           r_m_keep;
  logic            r_m_last;

  packer_state_t   w_state_next;
  logic            w_s_ready;
  logic            w_accept;
  logic            w_complete;
  logic [1:0]      w_count_next;
  logic [2:0][7:0] w_lane_next;
  logic [3:0][7:0] w_seq;
  genericUnion_t   w_word;

  // STALL doubles as the output-valid bit
  assign w_s_ready  = !rst && (r_state == FILL || bus.m_ready);
  assign w_accept   = bus.s_valid && w_s_ready;
  assign w_complete = w_accept && (r_count == 2'd3 || bus.s_last);

  always_comb begin
    w_seq = {4{PAD_VALUE}};
    if (r_count > 2'd0) w_seq[0] = r_lane[0];
    if (r_count > 2'd1) w_seq[1] = r_lane[1];
    if (r_count > 2'd2) w_seq[2] = r_lane[2];
    w_seq[r_count] = bus.s_data;
    w_word.data = LSB_FIRST ? w_seq : {w_seq[0], w_seq[1], w_seq[2], w_seq[3]};
  end

  always_comb begin
    w_lane_next  = r_lane;
    w_count_next = r_count;
    if (w_accept) begin
      if (w_complete) begin
        w_count_next = 2'd0;
      end else begin
        case (r_count)
          2'd0:    w_lane_next[0] = bus.s_data;
          2'd1:    w_lane_next[1] = bus.s_data;
          2'd2:    w_lane_next[2] = bus.s_data;
          default: ;
        endcase
        w_count_next = r_count + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_complete) w_state_next = STALL;
      STALL:   if (bus.m_ready && !w_complete) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FILL;
      r_count  <= 2'd0;
      r_lane   <= {3{PAD_VALUE}};
      r_m_data <= '0;
      r_m_keep <= '0;
      r_m_last <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_lane  <= w_lane_next;
      if (w_complete) begin
        r_m_data <= w_word;
        r_m_keep <= keep_mask(r_count, LSB_FIRST);
        r_m_last <= bus.s_last;
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = (r_state == STALL);
  assign bus.m_data  = r_m_data;
  assign bus.m_keep  = r_m_keep;
  assign bus.m_last  = r_m_last;

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - directed bench for both lane orders of the byte-to-word packer
module tb_byte_word_packer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  byte_word_packer_if bus_l ();
  byte_word_packer_if bus_m ();

  byte_word_packer #(.LSB_FIRST(1'b1), .PAD_VALUE(8'h00)) u_dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  byte_word_packer #(.LSB_FIRST(1'b0), .PAD_VALUE(8'h00)) u_dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic        ev;
    logic [31:0] el_data;
    logic [3:0]  el_keep;
    logic [31:0] em_data;
    logic [3:0]  em_keep;
    logic        e_last;
  } vec_t;

  vec_t vecs [16];

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    bus_l.s_valid = v; bus_l.s_data = d; bus_l.s_last = l;
    bus_m.s_valid = v; bus_m.s_data = d; bus_m.s_last = l;
  endtask

  task automatic set_ready(input logic r);
    bus_l.m_ready = r;
    bus_m.m_ready = r;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_word(input string tag, input logic [31:0] ld, input logic [3:0] lk,
                            input logic [31:0] md, input logic [3:0] mk, input logic last);
    check({tag, " l.valid"}, 32'(bus_l.m_valid), 32'd1);
    check({tag, " l.data"},  bus_l.m_data.data, ld);
    check({tag, " l.keep"},  32'(bus_l.m_keep), 32'(lk));
    check({tag, " l.last"},  32'(bus_l.m_last), 32'(last));
    check({tag, " m.valid"}, 32'(bus_m.m_valid), 32'd1);
    check({tag, " m.data"},  bus_m.m_data.data, md);
    check({tag, " m.keep"},  32'(bus_m.m_keep), 32'(mk));
    check({tag, " m.last"},  32'(bus_m.m_last), 32'(last));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " l.valid"}, 32'(bus_l.m_valid), 32'd0);
    check({tag, " m.valid"}, 32'(bus_m.m_valid), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_idle(tag);
    check({tag, " l.data"},  bus_l.m_data.data, 32'h0);
    check({tag, " l.keep"},  32'(bus_l.m_keep), 32'h0);
    check({tag, " l.last"},  32'(bus_l.m_last), 32'h0);
    check({tag, " l.ready"}, 32'(bus_l.s_ready), 32'h0);
    check({tag, " m.data"},  bus_m.m_data.data, 32'h0);
    check({tag, " m.ready"}, 32'(bus_m.s_ready), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] tail [4];
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{8'h11, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[1]  = '{8'h22, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[2]  = '{8'h33, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[3]  = '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b0};
    vecs[4]  = '{8'h55, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[5]  = '{8'h66, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[6]  = '{8'h77, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[7]  = '{8'h88, 1'b1, 1'b1, 32'h88776655, 4'hF, 32'h55667788, 4'hF, 1'b1};
    vecs[8]  = '{8'hAA, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[9]  = '{8'hBB, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[10] = '{8'hCC, 1'b1, 1'b1, 32'h00CCBBAA, 4'b0111, 32'hAABBCC00, 4'b1110, 1'b1};
    vecs[11] = '{8'h01, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[12] = '{8'h02, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[13] = '{8'h03, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0};
    vecs[14] = '{8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 1'b0};
    vecs[15] = '{8'h5A, 1'b1, 1'b1, 32'h0000005A, 4'b0001, 32'h5A000000, 4'b1000, 1'b1};

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // streaming table, m_ready held high: one byte accepted per cycle
    drive(1'b1, vecs[0].d, vecs[0].l);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (vecs[i].ev)
        check_word($sformatf("vec%0d", i), vecs[i].el_data, vecs[i].el_keep,
                   vecs[i].em_data, vecs[i].em_keep, vecs[i].e_last);
      else
        check_idle($sformatf("vec%0d", i));
      if (i < 15) drive(1'b1, vecs[i + 1].d, vecs[i + 1].l);
      else        drive(1'b0, 8'h00, 1'b0);
    end
    @(negedge clk);
    check_idle("drain");

    // backpressure: a completed word must hold while m_ready is low
    set_ready(1'b0);
    drive(1'b1, 8'hC1, 1'b0); @(negedge clk);
    drive(1'b1, 8'hC2, 1'b0); @(negedge clk);
    drive(1'b1, 8'hC3, 1'b0); @(negedge clk);
    drive(1'b1, 8'hC4, 1'b0); @(negedge clk);
    drive(1'b1, 8'hD1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      check_word($sformatf("stall%0d", j), 32'hC4C3C2C1, 4'hF, 32'hC1C2C3C4, 4'hF, 1'b0);
      check($sformatf("stall%0d l.ready", j), 32'(bus_l.s_ready), 32'd0);
      check($sformatf("stall%0d m.ready", j), 32'(bus_m.s_ready), 32'd0);
      @(negedge clk);
    end
    set_ready(1'b1);
    #1;
    check("release l.ready", 32'(bus_l.s_ready), 32'd1);
    check("release m.ready", 32'(bus_m.s_ready), 32'd1);
    @(negedge clk);
    check_idle("release");
    drive(1'b1, 8'hD2, 1'b0); @(negedge clk);
    drive(1'b1, 8'hD3, 1'b0); @(negedge clk);
    drive(1'b1, 8'hD4, 1'b1); @(negedge clk);
    check_word("after_stall", 32'hD4D3D2D1, 4'hF, 32'hD1D2D3D4, 4'hF, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("after_stall_drain");

    // asynchronous reset while a word is stalled at the output
    set_ready(1'b0);
    drive(1'b1, 8'hE1, 1'b0); @(negedge clk);
    drive(1'b1, 8'hE2, 1'b0); @(negedge clk);
    drive(1'b1, 8'hE3, 1'b0); @(negedge clk);
    drive(1'b1, 8'hE4, 1'b0); @(negedge clk);
    drive(1'b1, 8'hE5, 1'b0);
    check("pre_rst l.valid", 32'(bus_l.m_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    set_ready(1'b1);

    // reset mid-word: 01,02 must be discarded
    @(negedge clk);
    drive(1'b1, 8'h01, 1'b0); @(negedge clk);
    drive(1'b1, 8'h02, 1'b0); @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    tail[0] = 8'h03; tail[1] = 8'h04; tail[2] = 8'h05; tail[3] = 8'h06;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, tail[k], 1'b0);
      @(negedge clk);
      if (k == 3) check_word("midrst", 32'h06050403, 4'hF, 32'h03040506, 4'hF, 1'b0);
      else        check_idle($sformatf("midrst%0d", k));
    end
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("midrst_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
Upstream feeder for consumers of genericUnion_t. It accepts an 8-bit byte stream under a valid/ready handshake and packs the bytes into 32-bit words. Each word carries a byte-keep mask and a last flag. The packed word is presented as genericUnion_t so downstream logic can read it as .data or .bytes.byteN.

Parameters:
LSB_FIRST, 1, 1: first byte of a word lands in bytes.byte0; 0: first byte lands in bytes.byte3
PAD_VALUE, 8'h00, value driven into unfilled byte lanes of a partial word

Ports:
clk      in   1   sole clock, rising edge
rst      in   1   asynchronous, active-high reset
s_valid  in   1   input byte valid
s_ready  out  1   input byte accepted when s_valid && s_ready
s_data   in   8   input byte
s_last   in   1   byte ends a packet; closes the current word
m_valid  out  1   output word valid
m_ready  in   1   output word consumed when m_valid && m_ready
m_data   out  32  packed word, type genericUnion_t
m_keep   out  4   bit n set = bytes.byteN holds real data
m_last   out  1   word contains the packet's final byte

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: m_valid=0, m_data=0, m_keep=4'b0000, m_last=0, byte count=0, assembly register=PAD_VALUE in every lane, state=FILL. s_ready is forced to 0 while rst is high.
- Registers:
  - Assembly register: 3 bytes plus a 2-bit count, 0..3.
  - Output register: data, keep, last, valid.
- s_ready = !rst && (!m_valid || m_ready). It is combinational and never depends on s_valid or s_last.
- Accepted byte, count<3 and !s_last: write it to the lane for that count and increment the count.
- Word completion: a byte accepted with count==3 or with s_last=1.
  - The assembled lanes plus the current byte load the output register next cycle.
  - m_valid=1, m_last=s_last, count returns to 0.
  - Lanes never written are driven to PAD_VALUE.
- Lane mapping:
  - LSB_FIRST=1: byte k goes to byteK.
  - LSB_FIRST=0: byte k goes to byte(3-k).
- m_keep:
  - LSB_FIRST=1: n real bytes set the low n bits (n=3 gives 4'b0111).
  - LSB_FIRST=0: n real bytes set the high n bits (n=3 gives 4'b1110).
- Latency: one cycle from the accept of the completing byte to m_valid=1.
- Throughput: one byte per cycle sustained while m_ready=1.
- Simultaneous drain and complete: m_valid && m_ready together with a completing byte means the output register reloads with no bubble, and m_valid stays 1.
- Drain with nothing completing: m_valid && m_ready with no completing byte clears m_valid next cycle.
- Backpressure: while m_valid && !m_ready, m_data, m_keep and m_last hold stable and s_ready=0.
- State machine (enum):
  - FILL: count<3 and output free.
  - STALL: output full and not draining.
  - STALL -> FILL when m_ready=1.
  - The state is a decode aid only; the conditions above are normative.
- s_last with count==3 closes a full word: m_keep=4'hF, m_last=1.
- Reset asserted mid-word: the partial word is discarded with no output. After release the next byte starts a fresh word at lane 0 (LSB_FIRST=1) or lane 3 (LSB_FIRST=0).
- s_data and s_last are ignored when the input handshake does not complete.
- Word count rolls over after every 4th byte with no further side effect.

Decomposition:
- Shared package:
  - Reuse genericUnion_t from package demonstration for m_data.
  - Add BYTES_PER_WORD=4, the typedef keep_t (logic [3:0]), and the enum packer_state_t {FILL, STALL}.
- No sub-module. The assembly register, output register and handshake form one block of about 150 lines.

Test Plan:
- Reset: assert rst mid-simulation without a clock edge -> m_valid=0, m_keep=0, m_last=0, m_data=0, and s_ready=0 immediately.
- Full words, LSB_FIRST=1, m_ready=1: bytes 11..88 with s_last on 88 -> word 32'h44332211 keep F last 0, then 32'h88776655 keep F last 1, each one cycle after its completing byte.
- Partial word: AA,BB,CC with s_last on CC -> LSB_FIRST=1 gives 32'h00CCBBAA keep 4'b0111 last 1; LSB_FIRST=0 gives 32'hAABBCC00 keep 4'b1110 last 1.
- Backpressure: complete a word, hold m_ready=0 for 5 cycles while s_valid=1 -> s_ready=0, output stable for all 5 cycles; on m_ready=1 the word is consumed and the next byte is accepted the same cycle.
- Back-to-back: a full word followed immediately by a single byte 5A with s_last, m_ready=1 -> m_valid stays high across both words; second word is 32'h0000005A keep 4'b0001 last 1.
- Reset mid-word: accept 01,02, pulse rst, then send 03,04,05,06 -> exactly one word, 32'h06050403 keep F; the bytes 01 and 02 never appear.
